// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operator codes, state encoding and entry constants for the calculator controller
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      WAIT    = 3'd2,
      RESULT  = 3'd3,
      ERR     = 3'd4
   } calc_state_e;

   // Digit count after a clear, and the xor mask applied to a sign flag on unary minus
   localparam int   DIGIT_CLEAR = 0;
   localparam logic NEG_TOGGLE  = 1'b1;

endpackage

// File: rtl/calc_if.sv
// rtl/calc_if.sv - key strobes, ALU handshake and display bundle between controller and its environment
interface calc_if #(
   parameter int WIDTH = 16
);
   logic                    dig_strobe;
   logic                    reset_strobe;
   logic                    ex_strobe;
   logic                    op_strobe;
   logic                    sub_strobe;
   logic [3:0]              dig_code;
   logic [1:0]              op_code;
   logic                    alu_start;
   logic signed [WIDTH-1:0] alu_a;
   logic signed [WIDTH-1:0] alu_b;
   logic [1:0]              alu_op;
   logic                    alu_done;
   logic signed [WIDTH-1:0] alu_result;
   logic                    alu_err;
   logic signed [WIDTH-1:0] disp_value;
   logic                    error;
   logic                    busy;

   modport master (
      input  dig_strobe, reset_strobe, ex_strobe, op_strobe, sub_strobe, dig_code, op_code,
      input  alu_done, alu_result, alu_err,
      output alu_start, alu_a, alu_b, alu_op, disp_value, error, busy
   );

   modport slave (
      output dig_strobe, reset_strobe, ex_strobe, op_strobe, sub_strobe, dig_code, op_code,
      output alu_done, alu_result, alu_err,
      input  alu_start, alu_a, alu_b, alu_op, disp_value, error, busy
   );
endinterface

// File: rtl/operand_accum.sv
// rtl/operand_accum.sv - one decimal operand: magnitude, digit count and sign, with clear and direct load
module operand_accum
   import calc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clr_i,
   input  logic                               dig_en_i,
   input  logic [3:0]                         dig_i,
   input  logic                               neg_tgl_i,
   input  logic                               load_i,
   input  logic [WIDTH-1:0]                   load_val_i,
   output logic [WIDTH-1:0]                   value_o,
   output logic [$clog2(MAX_DIGITS+1)-1:0]    count_o
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic [WIDTH-1:0] mag_q, mag_d, mag_base;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
   logic             neg_q, neg_d, neg_base;

   // Clear is applied first so a clear and a digit in the same cycle starts a fresh operand with that digit
   always_comb begin
      mag_base = clr_i ? '0 : mag_q;
      cnt_base = clr_i ? CW'(DIGIT_CLEAR) : cnt_q;
      neg_base = clr_i ? 1'b0 : neg_q;
      mag_d    = mag_base;
      cnt_d    = cnt_base;
      neg_d    = neg_base;
      if (load_i) begin
         mag_d = load_val_i;
         neg_d = 1'b0;
      end else begin
         if (dig_en_i && (cnt_base < CW'(MAX_DIGITS))) begin
            mag_d = mag_base * WIDTH'(10) + WIDTH'(dig_i);
            cnt_d = cnt_base + CW'(1);
         end
         if (neg_tgl_i) begin
            neg_d = neg_base ^ NEG_TOGGLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mag_q <= '0;
         cnt_q <= '0;
         neg_q <= 1'b0;
      end else begin
         mag_q <= mag_d;
         cnt_q <= cnt_d;
         neg_q <= neg_d;
      end
   end

   assign value_o = neg_q ? -mag_q : mag_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/calc_controller.sv
// rtl/calc_controller.sv - calculator sequencing FSM: operand entry, ALU start/done handshake, display select
module calc_controller
   import calc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic   clk_i,
   input  logic   rst_i,
   calc_if.master bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   localparam logic [2:0] S_ENTER_A = ENTER_A;
   localparam logic [2:0] S_ENTER_B = ENTER_B;
   localparam logic [2:0] S_WAIT    = WAIT;
   localparam logic [2:0] S_RESULT  = RESULT;
   localparam logic [2:0] S_ERR     = ERR;

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             alu_start_q, alu_start_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] disp_q, disp_d;

   logic             key_clr, key_ex, key_op, key_dig;
   logic             a_clr, a_dig, a_tgl, a_load;
   logic             b_clr, b_dig, b_tgl;
   logic [WIDTH-1:0] a_val, b_val;
   logic [CW-1:0]    a_cnt, b_cnt;

   // Strobe priority: clear > equals > operator > digit
   assign key_clr = bus.reset_strobe;
   assign key_ex  = bus.ex_strobe & ~key_clr;
   assign key_op  = bus.op_strobe & ~key_clr & ~bus.ex_strobe;
   assign key_dig = bus.dig_strobe & ~key_clr & ~bus.ex_strobe & ~bus.op_strobe;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      alu_start_d = 1'b0;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      a_clr = 1'b0; a_dig = 1'b0; a_tgl = 1'b0; a_load = 1'b0;
      b_clr = 1'b0; b_dig = 1'b0; b_tgl = 1'b0;
      if (key_clr) begin
         state_d  = S_ENTER_A;
         op_d     = OP_ADD;
         alu_a_d  = '0;
         alu_b_d  = '0;
         alu_op_d = OP_ADD;
         a_clr    = 1'b1;
         b_clr    = 1'b1;
      end else begin
         case (state_q)
            S_ENTER_A: begin
               if (key_op) begin
                  if (a_cnt == '0) begin
                     a_tgl = bus.sub_strobe;
                  end else begin
                     op_d    = bus.op_code;
                     state_d = S_ENTER_B;
                  end
               end else if (key_dig) begin
                  a_dig = 1'b1;
               end
            end
            S_ENTER_B: begin
               if (key_ex && (b_cnt != '0)) begin
                  alu_start_d = 1'b1;
                  alu_a_d     = a_val;
                  alu_b_d     = b_val;
                  alu_op_d    = op_q;
                  state_d     = S_WAIT;
               end else if (key_op && (b_cnt == '0)) begin
                  if (bus.sub_strobe) b_tgl = 1'b1;
                  else                op_d  = bus.op_code;
               end else if (key_dig) begin
                  b_dig = 1'b1;
               end
            end
            S_WAIT: begin
               if (bus.alu_done) begin
                  if (bus.alu_err) begin
                     state_d = S_ERR;
                  end else begin
                     a_load  = 1'b1;
                     state_d = S_RESULT;
                  end
               end
            end
            S_RESULT: begin
               // The result stays as the left operand; minus here is an operator, not a sign
               if (key_op) begin
                  op_d    = bus.op_code;
                  b_clr   = 1'b1;
                  state_d = S_ENTER_B;
               end else if (key_dig) begin
                  a_clr   = 1'b1;
                  b_clr   = 1'b1;
                  a_dig   = 1'b1;
                  op_d    = OP_ADD;
                  state_d = S_ENTER_A;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      disp_d = a_val;
      if (key_clr || (state_q == S_ERR))              disp_d = '0;
      else if ((state_q == S_ENTER_B) && (b_cnt != '0)) disp_d = b_val;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_ENTER_A;
         op_q        <= OP_ADD;
         alu_start_q <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= OP_ADD;
         disp_q      <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         alu_start_q <= alu_start_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         disp_q      <= disp_d;
      end
   end

   operand_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (a_clr),
      .dig_en_i   (a_dig),
      .dig_i      (bus.dig_code),
      .neg_tgl_i  (a_tgl),
      .load_i     (a_load),
      .load_val_i (bus.alu_result),
      .value_o    (a_val),
      .count_o    (a_cnt)
   );

   operand_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (b_clr),
      .dig_en_i   (b_dig),
      .dig_i      (bus.dig_code),
      .neg_tgl_i  (b_tgl),
      .load_i     (1'b0),
      .load_val_i ('0),
      .value_o    (b_val),
      .count_o    (b_cnt)
   );

   assign bus.alu_start  = alu_start_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.disp_value = disp_q;
   assign bus.error      = (state_q == S_ERR);
   assign bus.busy       = (state_q == S_WAIT);

endmodule
